ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the 6-entry × 10-bit register RAM.
- Requester A and requester B each issue single-word read or write transactions. The block grants one transaction per cycle and drives the RAM's write, read, address and data inputs.
- Read data coming back from the RAM is routed to the requester that issued the read.
- The block runs on posedge clock. The RAM acts on negedge clock inside the same cycle in which this block drives the command.

Parameters:
- DW, 10, data width; must match the RAM word width.
- AW, 4, address width; must match the RAM address ports.
- DEPTH, 6, number of valid RAM entries; legal addresses are 0..DEPTH-1.

Ports:
- clock  in  1  system clock; block logic uses posedge.
- reset_n  in  1  asynchronous, active-low reset.
- a_req  in  1  requester A transaction request; held until a_gnt is seen.
- a_we  in  1  requester A direction: 1 = write, 0 = read.
- a_addr  in  AW  requester A word address.
- a_wdata  in  DW  requester A write data.
- a_gnt  out  1  one-cycle pulse: A's transaction was accepted.
- a_rvalid  out  1  one-cycle pulse: a_rdata holds A's read result.
- a_rdata  out  DW  read data for A.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same definitions as the A ports, for requester B.
- mem_write  out  1  connects to RAM write.
- mem_read  out  1  connects to RAM read.
- mem_addr_w  out  AW  connects to RAM addr_w.
- mem_addr_r  out  AW  connects to RAM addr_r.
- mem_datain  out  DW  connects to RAM datain.
- mem_dataout  in  DW  connects to RAM dataout.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All outputs go to 0.
  - Last-grant pointer is set to B, so A wins the first contention.
  - In-flight read tag is cleared.
  - Reset asserted mid-transaction aborts it: no gnt and no rvalid follow release.
  - Write data whose command was already driven may or may not land, depending on negedge timing; the bench must not check it.
- Arbitration, sampled at posedge at the end of cycle t:
  - Only A requesting → grant A.
  - Only B requesting → grant B.
  - Both requesting → grant the port that is not the last-grant pointer, then update the pointer.
  - Neither requesting → no grant; pointer unchanged.
- Grant cycle t+1:
  - gnt of the winner is high for exactly one cycle.
  - mem_* command outputs are registered with the winner's we, addr and wdata captured at the end of cycle t.
  - Write: mem_write=1, mem_addr_w=addr, mem_datain=wdata, mem_read=0.
  - Read: mem_read=1, mem_addr_r=addr, mem_write=0.
  - The inactive RAM address and data outputs hold their previous values.
  - In cycles with no grant, mem_write=0 and mem_read=0.
- Read return:
  - The RAM updates mem_dataout at the negedge inside cycle t+1.
  - The block captures mem_dataout at the posedge ending cycle t+1.
  - In cycle t+2 the originating port's rvalid=1 and its rdata=captured value.
  - rdata holds that value until the port's next read return.
  - Read latency: 2 cycles from the last req-sampling edge to the rvalid cycle.
- Requester handshake:
  - While req is high, the requester keeps we, addr and wdata stable.
  - During the cycle its gnt is high, the requester either drops req or presents the next transaction.
  - req still high at the end of a gnt cycle is treated as a new request. This gives back-to-back throughput of one transaction per cycle.
  - With both ports continuously requesting, grants alternate A, B, A, B.
- Simultaneous events:
  - A read by one port and a write by the other are never issued in the same cycle; at most one command per cycle.
  - A read return for one port can coincide with a grant to either port.
- Same-address ordering:
  - A write granted in cycle t+1 is visible to a read granted in cycle t+2 or later.
- Address range:
  - With the optional feature compiled out, addresses ≥ DEPTH are passed to the RAM unchanged.
  - For such an address the RAM ignores writes, and a read returns the RAM's previous dataout.

Optional Feature:
- Macro: RAM_ARB_ERR_EN.
- Defined:
  - Adds outputs a_err and b_err, each 1 bit, reset 0.
  - A granted transaction with addr ≥ DEPTH still pulses gnt.
  - It drives mem_write=0 and mem_read=0 for that cycle.
  - It pulses the port's err in cycle t+2. For a read, rvalid pulses in cycle t+2 with rdata = 0.
- Undefined:
  - No err ports exist.
  - Behaviour follows the address-range rule above.

Test Plan:
- Write and read back: A writes addr 3 = 10'h2A5 → mem_write=1, mem_addr_w=3 in the grant cycle. A then reads addr 3 → a_rvalid two cycles after sampling, a_rdata=10'h2A5.
- Contention after reset: a_req and b_req rise together; A reads addr 0, B writes addr 1 = 10'h155 → a_gnt first, b_gnt next cycle; b_gnt never coincides with a_gnt.
- Continuous fairness: both ports request continuously for 8 cycles → grants A,B,A,B,A,B,A,B; each port receives 4 grants.
- Back-to-back B: B writes addr 5 = 10'h3FF and immediately reads addr 5 → b_rvalid with b_rdata=10'h3FF, 2 cycles after the read's sampling edge.
- Reset during operation: reset_n pulsed low between an A read grant and its return → a_rvalid never pulses; all outputs 0 during reset.
- RAM_ARB_ERR_EN defined: A writes addr 7 → a_gnt=1, mem_write stays 0, a_err pulses in cycle t+2. A then reads addr 7 → a_rvalid with a_rdata=0 and a_err pulse.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a negedge-clocked register RAM.
// Optional: define RAM_ARB_ERR_EN to add a_err/b_err and block out-of-range RAM commands.
module ram_arbiter #(
  parameter int unsigned DW    = 10,
  parameter int unsigned AW    = 4,
  parameter int unsigned DEPTH = 6
) (
  input  logic          clock,
  input  logic          reset_n,

  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,

  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,

`ifdef RAM_ARB_ERR_EN
  output logic          a_err,
  output logic          b_err,
`endif

  output logic          mem_write,
  output logic          mem_read,
  output logic [AW-1:0] mem_addr_w,
  output logic [AW-1:0] mem_addr_r,
  output logic [DW-1:0] mem_datain,
  input  logic [DW-1:0] mem_dataout
);

  typedef enum logic {
    PortA = 1'b0,
    PortB = 1'b1
  } port_e;

  port_e         r_last;
  port_e         w_last_d;

  logic          w_gnt_a;
  logic          w_gnt_b;
  logic          w_sel_any;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic          w_sel_oor;
  logic          w_cmd_ok;

  logic          r_a_gnt;
  logic          r_b_gnt;
  logic          r_mem_write;
  logic          r_mem_read;
  logic [AW-1:0] r_mem_addr_w;
  logic [AW-1:0] r_mem_addr_r;
  logic [DW-1:0] r_mem_datain;

  // Read tags: which port owns the RAM read issued in the current cycle.
  logic          r_rd_a;
  logic          r_rd_b;
  logic          r_a_rvalid;
  logic          r_b_rvalid;
  logic [DW-1:0] r_a_rdata;
  logic [DW-1:0] r_b_rdata;

`ifdef RAM_ARB_ERR_EN
  logic          r_perr_a;
  logic          r_perr_b;
  logic          r_perd_a;
  logic          r_perd_b;
  logic          r_a_err;
  logic          r_b_err;
`endif

  always_comb begin
    w_gnt_a  = 1'b0;
    w_gnt_b  = 1'b0;
    w_last_d = r_last;
    if (a_req && (!b_req || (r_last == PortB))) begin
      w_gnt_a = 1'b1;
    end else if (b_req) begin
      w_gnt_b = 1'b1;
    end
    if (w_gnt_a) begin
      w_last_d = PortA;
    end else if (w_gnt_b) begin
      w_last_d = PortB;
    end
  end

  always_comb begin
    w_sel_any   = w_gnt_a | w_gnt_b;
    w_sel_we    = w_gnt_a ? a_we    : b_we;
    w_sel_addr  = w_gnt_a ? a_addr  : b_addr;
    w_sel_wdata = w_gnt_a ? a_wdata : b_wdata;
  end

`ifdef RAM_ARB_ERR_EN
  assign w_sel_oor = w_sel_any && (w_sel_addr >= AW'(DEPTH));
`else
  // Out-of-range addresses go to the RAM untouched; the RAM ignores them.
  assign w_sel_oor = 1'b0;
`endif

  assign w_cmd_ok = w_sel_any & ~w_sel_oor;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last       <= PortB;
      r_a_gnt      <= 1'b0;
      r_b_gnt      <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_addr_w <= '0;
      r_mem_addr_r <= '0;
      r_mem_datain <= '0;
    end else begin
      r_last      <= w_last_d;
      r_a_gnt     <= w_gnt_a;
      r_b_gnt     <= w_gnt_b;
      r_mem_write <= w_cmd_ok & w_sel_we;
      r_mem_read  <= w_cmd_ok & ~w_sel_we;
      if (w_cmd_ok && w_sel_we) begin
        r_mem_addr_w <= w_sel_addr;
        r_mem_datain <= w_sel_wdata;
      end
      if (w_cmd_ok && !w_sel_we) begin
        r_mem_addr_r <= w_sel_addr;
      end
    end
  end

  // RAM updates dataout at the negedge of the command cycle; capture at the following posedge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_a     <= 1'b0;
      r_rd_b     <= 1'b0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
`ifdef RAM_ARB_ERR_EN
      r_perr_a   <= 1'b0;
      r_perr_b   <= 1'b0;
      r_perd_a   <= 1'b0;
      r_perd_b   <= 1'b0;
      r_a_err    <= 1'b0;
      r_b_err    <= 1'b0;
`endif
    end else begin
      r_rd_a <= w_gnt_a & ~a_we & w_cmd_ok;
      r_rd_b <= w_gnt_b & ~b_we & w_cmd_ok;
`ifdef RAM_ARB_ERR_EN
      r_perr_a   <= w_gnt_a & w_sel_oor;
      r_perr_b   <= w_gnt_b & w_sel_oor;
      r_perd_a   <= w_gnt_a & w_sel_oor & ~a_we;
      r_perd_b   <= w_gnt_b & w_sel_oor & ~b_we;
      r_a_err    <= r_perr_a;
      r_b_err    <= r_perr_b;
      r_a_rvalid <= r_rd_a | r_perd_a;
      r_b_rvalid <= r_rd_b | r_perd_b;
      if (r_rd_a) begin
        r_a_rdata <= mem_dataout;
      end else if (r_perd_a) begin
        r_a_rdata <= '0;
      end
      if (r_rd_b) begin
        r_b_rdata <= mem_dataout;
      end else if (r_perd_b) begin
        r_b_rdata <= '0;
      end
`else
      r_a_rvalid <= r_rd_a;
      r_b_rvalid <= r_rd_b;
      if (r_rd_a) begin
        r_a_rdata <= mem_dataout;
      end
      if (r_rd_b) begin
        r_b_rdata <= mem_dataout;
      end
`endif
    end
  end

  assign a_gnt      = r_a_gnt;
  assign b_gnt      = r_b_gnt;
  assign a_rvalid   = r_a_rvalid;
  assign b_rvalid   = r_b_rvalid;
  assign a_rdata    = r_a_rdata;
  assign b_rdata    = r_b_rdata;
  assign mem_write  = r_mem_write;
  assign mem_read   = r_mem_read;
  assign mem_addr_w = r_mem_addr_w;
  assign mem_addr_r = r_mem_addr_r;
  assign mem_datain = r_mem_datain;
`ifdef RAM_ARB_ERR_EN
  assign a_err      = r_a_err;
  assign b_err      = r_b_err;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed testbench for ram_arbiter with a behavioural negedge register RAM.
// Covers the RAM_ARB_ERR_EN build when that macro is defined.
module tb_ram_arbiter;

  localparam int unsigned DW    = 10;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 6;

  logic          clock;
  logic          reset_n;
  logic          a_req, a_we, a_gnt, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_req, b_we, b_gnt, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic          mem_write, mem_read;
  logic [AW-1:0] mem_addr_w, mem_addr_r;
  logic [DW-1:0] mem_datain, mem_dataout;
`ifdef RAM_ARB_ERR_EN
  logic          a_err, b_err;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] ram [DEPTH];

  ram_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .a_req      (a_req),
    .a_we       (a_we),
    .a_addr     (a_addr),
    .a_wdata    (a_wdata),
    .a_gnt      (a_gnt),
    .a_rvalid   (a_rvalid),
    .a_rdata    (a_rdata),
    .b_req      (b_req),
    .b_we       (b_we),
    .b_addr     (b_addr),
    .b_wdata    (b_wdata),
    .b_gnt      (b_gnt),
    .b_rvalid   (b_rvalid),
    .b_rdata    (b_rdata),
`ifdef RAM_ARB_ERR_EN
    .a_err      (a_err),
    .b_err      (b_err),
`endif
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .mem_addr_w (mem_addr_w),
    .mem_addr_r (mem_addr_r),
    .mem_datain (mem_datain),
    .mem_dataout(mem_dataout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register RAM: acts on negedge, ignores out-of-range addresses.
  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    mem_dataout = '0;
  end
  always @(negedge clock) begin
    if (mem_write && (mem_addr_w < AW'(DEPTH))) ram[mem_addr_w] <= mem_datain;
    if (mem_read && (mem_addr_r < AW'(DEPTH))) mem_dataout <= ram[mem_addr_r];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  int na, nb;

  initial begin
    reset_n = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    tick();
    check_eq("rst_a_gnt", a_gnt, 0);
    check_eq("rst_mem_write", mem_write, 0);
    check_eq("rst_mem_read", mem_read, 0);
    check_eq("rst_a_rdata", a_rdata, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Write 3 = 2A5, then read it back.
    a_req = 1; a_we = 1; a_addr = 3; a_wdata = 10'h2A5;
    tick();
    check_eq("wr_a_gnt", a_gnt, 1);
    check_eq("wr_mem_write", mem_write, 1);
    check_eq("wr_mem_read", mem_read, 0);
    check_eq("wr_addr_w", mem_addr_w, 3);
    check_eq("wr_datain", mem_datain, 10'h2A5);
    a_we = 0;
    tick();
    check_eq("rd_a_gnt", a_gnt, 1);
    check_eq("rd_mem_read", mem_read, 1);
    check_eq("rd_mem_write", mem_write, 0);
    check_eq("rd_addr_r", mem_addr_r, 3);
    check_eq("rd_addr_w_hold", mem_addr_w, 3);
    a_req = 0;
    tick();
    check_eq("rd_a_rvalid", a_rvalid, 1);
    check_eq("rd_a_rdata", a_rdata, 10'h2A5);
    check_eq("rd_a_gnt_off", a_gnt, 0);
    tick();
    check_eq("rd_a_rvalid_off", a_rvalid, 0);
    check_eq("rd_a_rdata_hold", a_rdata, 10'h2A5);

`ifdef RAM_ARB_ERR_EN
    // Out-of-range write then read: commands suppressed, err pulses two cycles later.
    a_req = 1; a_we = 1; a_addr = 7; a_wdata = 10'h0F0;
    tick();
    check_eq("ew_a_gnt", a_gnt, 1);
    check_eq("ew_mem_write", mem_write, 0);
    check_eq("ew_a_err_early", a_err, 0);
    a_we = 0;
    tick();
    check_eq("er_a_gnt", a_gnt, 1);
    check_eq("er_mem_read", mem_read, 0);
    check_eq("ew_a_err", a_err, 1);
    check_eq("ew_a_rvalid", a_rvalid, 0);
    a_req = 0;
    tick();
    check_eq("er_a_err", a_err, 1);
    check_eq("er_a_rvalid", a_rvalid, 1);
    check_eq("er_a_rdata", a_rdata, 0);
    tick();
    check_eq("er_a_err_off", a_err, 0);
    check_eq("er_b_err", b_err, 0);
`else
    // Out-of-range write then read pass straight to the RAM; read returns stale dataout.
    a_req = 1; a_we = 1; a_addr = 7; a_wdata = 10'h0F0;
    tick();
    check_eq("oor_mem_write", mem_write, 1);
    check_eq("oor_addr_w", mem_addr_w, 7);
    a_we = 0;
    tick();
    check_eq("oor_mem_read", mem_read, 1);
    check_eq("oor_addr_r", mem_addr_r, 7);
    a_req = 0;
    tick();
    check_eq("oor_a_rvalid", a_rvalid, 1);
    check_eq("oor_a_rdata", a_rdata, 10'h2A5);
    tick();
`endif

    // Contention straight after reset: A first.
    do_reset();
    a_req = 1; a_we = 0; a_addr = 0;
    b_req = 1; b_we = 1; b_addr = 1; b_wdata = 10'h155;
    tick();
    check_eq("ct_a_gnt", a_gnt, 1);
    check_eq("ct_b_gnt0", b_gnt, 0);
    check_eq("ct_mem_read", mem_read, 1);
    check_eq("ct_addr_r", mem_addr_r, 0);
    a_req = 0;
    tick();
    check_eq("ct_b_gnt", b_gnt, 1);
    check_eq("ct_a_gnt_off", a_gnt, 0);
    check_eq("ct_mem_write", mem_write, 1);
    check_eq("ct_addr_w", mem_addr_w, 1);
    check_eq("ct_datain", mem_datain, 10'h155);
    check_eq("ct_addr_r_hold", mem_addr_r, 0);
    check_eq("ct_a_rvalid", a_rvalid, 1);
    check_eq("ct_a_rdata", a_rdata, 0);
    b_req = 0;
    tick();
    check_eq("ct_b_gnt_off", b_gnt, 0);
    check_eq("ct_a_rvalid_off", a_rvalid, 0);

    // Continuous fairness from reset: A,B,A,B,...
    do_reset();
    a_req = 1; a_we = 1; a_addr = 2; a_wdata = 10'h0AA;
    b_req = 1; b_we = 1; b_addr = 4; b_wdata = 10'h111;
    na = 0; nb = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq($sformatf("rr_a_gnt%0d", i), a_gnt, (i % 2 == 0) ? 1 : 0);
      check_eq($sformatf("rr_b_gnt%0d", i), b_gnt, (i % 2 == 1) ? 1 : 0);
      if (a_gnt) na++;
      if (b_gnt) nb++;
    end
    check_eq("rr_na", na, 4);
    check_eq("rr_nb", nb, 4);
    a_req = 0; b_req = 0;
    tick();
    check_eq("rr_idle_write", mem_write, 0);
    check_eq("rr_idle_gnt", a_gnt | b_gnt, 0);

    // Back-to-back B write then read of address 5.
    b_req = 1; b_we = 1; b_addr = 5; b_wdata = 10'h3FF;
    tick();
    check_eq("bb_b_gnt_w", b_gnt, 1);
    check_eq("bb_addr_w", mem_addr_w, 5);
    b_we = 0;
    tick();
    check_eq("bb_b_gnt_r", b_gnt, 1);
    check_eq("bb_mem_read", mem_read, 1);
    check_eq("bb_addr_r", mem_addr_r, 5);
    b_req = 0;
    tick();
    check_eq("bb_b_rvalid", b_rvalid, 1);
    check_eq("bb_b_rdata", b_rdata, 10'h3FF);
    check_eq("bb_a_rvalid", a_rvalid, 0);

    // Reset between an A read grant and its return.
    a_req = 1; a_we = 0; a_addr = 3;
    tick();
    check_eq("rs_a_gnt", a_gnt, 1);
    a_req = 0;
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("rs_a_gnt0", a_gnt, 0);
    check_eq("rs_mem_read0", mem_read, 0);
    check_eq("rs_addr_r0", mem_addr_r, 0);
    check_eq("rs_b_rdata0", b_rdata, 0);
    tick();
    check_eq("rs_a_rvalid_in", a_rvalid, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("rs_a_rvalid%0d", i), a_rvalid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
